// File: rtl/fetch_pc_unit.sv
// Fetch front end: fetch PC, predictor lookup, one-outstanding imem fetch and fetch queue.
// Optional FETCH_PERF_EN adds saturating fetched/flushed/stall counters.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] old_PC,
    output logic        predict_en,
    input  logic [31:0] new_PC,
    input  logic        predict_jump,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_pred_jump,
    output logic [31:0] id_pred_target
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_stall
`endif
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {FETCH, WAIT_RSP, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_q, wr_q;
    logic            req_q;
    logic [31:0]     if_pc_q, if_tgt_q;
    logic            if_jmp_q;

    logic [31:0]     fq_pc_q   [FQ_DEPTH];
    logic [31:0]     fq_inst_q [FQ_DEPTH];
    logic [31:0]     fq_tgt_q  [FQ_DEPTH];
    logic            fq_jmp_q  [FQ_DEPTH];

    logic            waiting, grant, push, pop;
    logic            unused_pc_lsbs;

    assign unused_pc_lsbs = ^{new_PC[1:0], redirect_pc[1:0]};

    assign waiting = (state_q != FETCH);
    assign grant   = req_q && imem_gnt;
    assign push    = !redirect_valid && (state_q == WAIT_RSP) && imem_rvalid;
    assign pop     = !redirect_valid && id_valid && id_ready;

    assign old_PC     = pc_q;
    assign imem_addr  = pc_q;
    assign imem_req   = req_q;
    assign predict_en = req_q;

    assign id_valid       = (count_q != '0);
    assign id_pc          = fq_pc_q[rd_q];
    assign id_inst        = fq_inst_q[rd_q];
    assign id_pred_jump   = fq_jmp_q[rd_q];
    assign id_pred_target = fq_tgt_q[rd_q];

    // A grant in the redirect cycle still leaves a response to swallow.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = ((waiting && !imem_rvalid) || grant) ? DRAIN : FETCH;
        end else begin
            unique case (state_q)
                FETCH:    if (grant)       state_d = WAIT_RSP;
                WAIT_RSP: if (imem_rvalid) state_d = FETCH;
                DRAIN:    if (imem_rvalid) state_d = FETCH;
                default:                   state_d = FETCH;
            endcase
        end
    end

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        if (redirect_valid) count_d = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            req_q    <= 1'b0;
            if_pc_q  <= '0;
            if_tgt_q <= '0;
            if_jmp_q <= 1'b0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_pc_q[i]   <= '0;
                fq_inst_q[i] <= '0;
                fq_tgt_q[i]  <= '0;
                fq_jmp_q[i]  <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            // Request only with a queue slot reserved for its response.
            req_q   <= (state_d == FETCH) && (count_d < CW'(FQ_DEPTH));
            if (redirect_valid) begin
                pc_q <= {redirect_pc[31:2], 2'b00};
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                if (grant) begin
                    pc_q     <= {new_PC[31:2], 2'b00};
                    if_pc_q  <= pc_q;
                    if_jmp_q <= predict_jump;
                    if_tgt_q <= {new_PC[31:2], 2'b00};
                end
                if (push) begin
                    fq_pc_q[wr_q]   <= if_pc_q;
                    fq_inst_q[wr_q] <= imem_rdata;
                    fq_jmp_q[wr_q]  <= if_jmp_q;
                    fq_tgt_q[wr_q]  <= if_tgt_q;
                    wr_q            <= wr_q + AW'(1);
                end
                if (pop) rd_q <= rd_q + AW'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_flushed_q, perf_stall_q;
    logic [32:0] flush_sum;
    logic        drain_drop;

    assign drain_drop = (state_q == DRAIN) && imem_rvalid;
    assign flush_sum  = {1'b0, perf_flushed_q}
                      + (redirect_valid ? 33'(count_q) : 33'd0)
                      + 33'(drain_drop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push && perf_fetched_q != '1)
                perf_fetched_q <= perf_fetched_q + 32'd1;
            perf_flushed_q <= flush_sum[32] ? '1 : flush_sum[31:0];
            if (state_q == FETCH && count_q == CW'(FQ_DEPTH)
                && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a scoreboard of expected
// queue entries checked as decode pops them.
module tb_fetch_pc_unit;

    logic        clk;
    logic        resetn;
    logic [31:0] old_PC;
    logic        predict_en;
    logic [31:0] new_PC;
    logic        predict_jump;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_pred_jump;
    logic [31:0] id_pred_target;

    fetch_pc_unit #(.RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .old_PC(old_PC), .predict_en(predict_en),
        .new_PC(new_PC), .predict_jump(predict_jump),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_inst(id_inst),
        .id_pred_jump(id_pred_jump), .id_pred_target(id_pred_target)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        jmp;
        logic [31:0] tgt;
    } ent_t;

    ent_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic        pred_on;
    logic [31:0] pred_src, pred_dst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        if (pred_on && old_PC == pred_src) begin
            new_PC       = pred_dst;
            predict_jump = 1'b1;
        end else begin
            new_PC       = old_PC + 32'd4;
            predict_jump = 1'b0;
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1300_0013 ^ (a << 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        ent_t e;
        if (redirect_valid) begin
            sb.delete();
        end else if (id_valid && id_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_entry observed id_pc=%h expected=none",
                       id_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("id_pc", id_pc, e.pc);
                chk("id_inst", id_inst, e.inst);
                chk("id_pred_jump", 32'(id_pred_jump), 32'(e.jmp));
                chk("id_pred_target", id_pred_target, e.tgt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_wait", 32'(imem_req), 32'd1);
    endtask

    task automatic fetch_one(input logic [31:0] addr);
        ent_t e;
        wait_req();
        chk("imem_addr", imem_addr, addr);
        chk("predict_en", 32'(predict_en), 32'd1);
        e.pc   = addr;
        e.inst = mem_word(addr);
        e.jmp  = pred_on && (addr == pred_src);
        e.tgt  = e.jmp ? pred_dst : addr + 32'd4;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("req_in_wait", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = e.inst;
        sb.push_back(e);
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic drain_q();
        int n = 0;
        while (id_valid && n < 20) begin
            tick();
            n++;
        end
        chk("drained_valid", 32'(id_valid), 32'd0);
        chk("sb_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        id_ready       = 1'b1;
        pred_on        = 1'b0;
        pred_src       = '0;
        pred_dst       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pen", 32'(predict_en), 32'd0);
        chk("rst_idv", 32'(id_valid), 32'd0);
        chk("rst_idpc", id_pc, 32'd0);
        chk("rst_idinst", id_inst, 32'd0);
        chk("rst_pc", old_PC, 32'd0);
        resetn = 1'b1;

        // Sequential not-taken fetch
        fetch_one(32'h0);
        fetch_one(32'h4);
        fetch_one(32'h8);
        fetch_one(32'hC);

        // Predicted-taken branch at 0x10
        pred_on  = 1'b1;
        pred_src = 32'h10;
        pred_dst = 32'h80;
        fetch_one(32'h10);
        pred_on  = 1'b0;
        fetch_one(32'h80);
        drain_q();

        // Fill the queue with decode stalled
        id_ready = 1'b0;
        fetch_one(32'h84);
        fetch_one(32'h88);
        fetch_one(32'h8C);
        fetch_one(32'h90);
        chk("full_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        chk("full_req2", 32'(imem_req), 32'd0);
        tick();
        chk("full_req3", 32'(imem_req), 32'd0);
        chk("full_idv", 32'(id_valid), 32'd1);
        chk("full_head", id_pc, 32'h84);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("pop_req", 32'(imem_req), 32'd1);
        chk("pop_addr", imem_addr, 32'h94);
        fetch_one(32'h94);
        chk("refull_req", 32'(imem_req), 32'd0);
        id_ready = 1'b1;
        drain_q();

        // Redirect while waiting for a response
        wait_req();
        chk("rd_addr", imem_addr, 32'h98);
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        chk("drain_req", 32'(imem_req), 32'd0);
        chk("drain_idv", 32'(id_valid), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("drop_idv", 32'(id_valid), 32'd0);
        chk("after_drain_req", 32'(imem_req), 32'd1);
        chk("after_drain_addr", imem_addr, 32'h200);
        fetch_one(32'h200);

        // Redirect coincident with grant and pop
        chk("coinc_idv", 32'(id_valid), 32'd1);
        chk("coinc_addr", imem_addr, 32'h204);
        id_ready       = 1'b1;
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        chk("coinc_flush", 32'(id_valid), 32'd0);
        chk("coinc_drain", 32'(imem_req), 32'd0);
        chk("coinc_pc", old_PC, 32'h300);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFEED_F00D;
        tick();
        imem_rvalid = 1'b0;
        chk("coinc_drop", 32'(id_valid), 32'd0);
        chk("coinc_req", 32'(imem_req), 32'd1);
        chk("coinc_addr2", imem_addr, 32'h300);

        // Async reset mid-WAIT_RSP with three entries queued
        id_ready = 1'b0;
        fetch_one(32'h300);
        fetch_one(32'h304);
        fetch_one(32'h308);
        wait_req();
        chk("mr_addr", imem_addr, 32'h30C);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("mr_idv_pre", 32'(id_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_idv", 32'(id_valid), 32'd0);
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_pen", 32'(predict_en), 32'd0);
        chk("mr_idpc", id_pc, 32'd0);
        sb.delete();
        tick();
        resetn   = 1'b1;
        id_ready = 1'b1;
        fetch_one(32'h0);
        fetch_one(32'h4);
        drain_q();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch front end directly upstream of the BTB branch predictor. Holds the architectural fetch PC and drives it to the predictor as old_PC with predict_en. Consumes new_PC/predict_jump as the next PC. Issues one-outstanding-request fetches to instruction memory and buffers fetched instructions, tagged with their prediction, in a small FIFO for decode. Accepts redirects from execute on mispredict.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FQ_DEPTH, 4, fetch-queue entries (power of 2, 2..16)

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
old_PC  out  32  current fetch PC to predictor
predict_en  out  1  predictor lookup valid (equals imem_req)
new_PC  in  32  predicted next PC from predictor (combinational)
predict_jump  in  1  predictor says taken
redirect_valid  in  1  execute-stage redirect (mispredict/exception)
redirect_pc  in  32  corrected fetch PC
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (= old_PC)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  fetched instruction
id_valid  out  1  queue head valid to decode
id_ready  in  1  decode accepts head
id_pc  out  32  PC of head instruction
id_inst  out  32  head instruction
id_pred_jump  out  1  prediction stored with head
id_pred_target  out  32  predicted next PC stored with head

Behaviour:
- Reset (async, resetn=0): pc=RESET_PC, state=FETCH, queue empty, count=0; outputs imem_req=0, predict_en=0, id_valid=0, id_* =0.
- pc[1:0] always held 0; new_PC and redirect_pc loaded with bits [1:0] forced to 0.
- States: FETCH, WAIT_RSP, DRAIN.
- FETCH: imem_req=1 iff (count + 1) <= FQ_DEPTH, i.e. count < FQ_DEPTH; old_PC=imem_addr=pc. On imem_gnt: latch inflight {pc, predict_jump, new_PC}, pc<=new_PC, go to WAIT_RSP.
- WAIT_RSP: imem_req=0. On imem_rvalid: push {inflight_pc, imem_rdata, inflight_pred, inflight_target}, go to FETCH. Response is accepted in the cycle it arrives; a request may be issued at the earliest one cycle later.
- DRAIN: imem_req=0. On imem_rvalid: discard the data, go to FETCH.
- Redirect has highest priority. In the cycle with redirect_valid=1: queue flushed (count=0, id_valid=0 next cycle), pc<=redirect_pc. Any push or grant in the same cycle is dropped. Next state: DRAIN if a request is outstanding or granted this cycle, and no rvalid ends it this cycle; otherwise FETCH.
- Queue: circular buffer, FQ_DEPTH entries, wrap-around pointers, count width clog2(FQ_DEPTH)+1. Pop when id_valid&&id_ready. Simultaneous push and pop: count unchanged. Push is never blocked, because a request is only issued with space reserved. id_* = head entry, registered storage, no bypass; a pushed entry is visible the following cycle.
- Full: count==FQ_DEPTH, imem_req=0 until a pop occurs.
- imem_rvalid outside WAIT_RSP/DRAIN: ignored.
- pc+4 wraps modulo 2^32 (arithmetic done by the predictor; no overflow detection here).

Optional Feature:
FETCH_PERF_EN: when defined, adds 32-bit saturating counters perf_fetched (increments on each push), perf_flushed (increments by count on each redirect, plus 1 per discarded DRAIN response) and perf_stall (increments on each FETCH cycle with the queue full). Each counter has its own output port; all reset to 0. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_PC=0, predictor not-taken (new_PC=pc+4), gnt and rvalid each one cycle after the previous event, id_ready=1 -> id_pc sequence 0,4,8,C; id_pred_jump=0.
- At pc=0x10, predict_jump=1 and new_PC=0x80 -> next imem_addr=0x80; the entry for 0x10 has id_pred_jump=1, id_pred_target=0x80.
- id_ready=0, FQ_DEPTH=4 -> exactly 4 pushes, then imem_req=0; one pop -> imem_req=1 the next cycle.
- Redirect to 0x200 while in WAIT_RSP -> state DRAIN, the following rvalid data is not pushed, queue empty, next imem_addr=0x200.
- redirect_valid coincident with imem_gnt and a pop -> the grant is discarded via DRAIN, count=0, pc=redirect_pc.
- Assert resetn=0 mid-WAIT_RSP with 3 entries queued -> immediately id_valid=0, imem_req=0; after release, first imem_addr=RESET_PC.
